shared_reg_arbiter: RTL

Round-robin arbiter and load sequencer for a single shared DW-bit D-flip-flop data register written by N_REQ requesters. It grants one requester at a time, issues a single load strobe that captures that requester's data into the shared register, acknowledges the winner, and holds the grant for a fixed guard interval before re-arbitrating. It sits between the control units that produce values and the shared storage register they all drive.

---
 rtl/shared_reg_arbiter.sv | 83 ++++++++
 1 files changed

// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: round-robin arbiter that sequences writes from N_REQ requesters
// into one shared DW-bit register, holding the grant for HOLD_CYC guard cycles.
module shared_reg_arbiter #(
    parameter int N_REQ    = 4,
    parameter int DW       = 8,
    parameter int HOLD_CYC = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] data_in,
    output logic [DW-1:0]       q,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    ack,
    output logic                load,
    output logic                busy
);
    localparam int PW = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

    state_t        state, state_d;
    logic [PW-1:0] ptr, win, pick;
    logic [3:0]    cnt;

    // Later-searched candidates are overwritten, so the first set bit after ptr wins.
    always_comb begin
        pick = ptr;
        for (int k = N_REQ; k >= 1; k--)
            if (req[(int'(ptr) + k) % N_REQ]) pick = PW'((int'(ptr) + k) % N_REQ);
    end

    always_comb begin
        state_d = state;
        load    = 1'b0;
        busy    = 1'b0;
        ack     = '0;
        case (state)
            IDLE: state_d = (|req) ? LOAD : IDLE;
            LOAD: begin
                state_d = (HOLD_CYC > 0) ? HOLD : IDLE;
                load    = 1'b1;
                busy    = 1'b1;
                ack     = gnt;
            end
            HOLD: begin
                state_d = (cnt == 4'd1) ? IDLE : HOLD;
                busy    = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            q     <= '0;
            gnt   <= '0;
            ptr   <= PW'(N_REQ - 1);
            win   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_d;
            case (state)
                IDLE: if (|req) begin
                    gnt <= N_REQ'(1) << pick;
                    win <= pick;
                end
                LOAD: begin
                    q   <= data_in[int'(win)*DW +: DW];
                    ptr <= win;
                    cnt <= 4'(HOLD_CYC);
                    if (HOLD_CYC == 0) gnt <= '0;
                end
                HOLD: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) gnt <= '0;
                end
                default: gnt <= '0;
            endcase
        end
    end
endmodule
